// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide into HI/LO, one bit per cycle.
// Signed ops run on magnitudes; the sign is restored in a single fixup cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0] msum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        sa = a[WIDTH-1] & ~op[0];
        sb = b[WIDTH-1] & ~op[0];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
        // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
        msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opnd_q : '0};
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff = rem_sh - {1'b0, opnd_q};
        prod = neg_res_q ? -acc_q : acc_q;
        state_d = state_q;
        cnt_d = cnt_q;
        is_div_d = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d = dbz_q;
        opnd_d = opnd_q;
        acc_d = acc_q;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: if (start) begin
                is_div_d = op[1];
                neg_res_d = sa ^ sb;
                neg_rem_d = sa;
                opnd_d = op[1] ? mag_b : mag_a;
                acc_d = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                cnt_d = '0;
                dbz_d = op[1] && (b == '0);
                hi_d = dbz_d ? a : hi_q;
                lo_d = dbz_d ? '1 : lo_q;
                state_d = dbz_d ? DONE : CALC;
            end
            CALC: begin
                acc_d = !is_div_q ? {msum, acc_q[WIDTH-1:1]} :
                        diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                      {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
            end
            FIX: begin
                hi_d = !is_div_q ? prod[2*WIDTH-1:WIDTH] :
                       neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                lo_d = !is_div_q ? prod[WIDTH-1:0] :
                       neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            is_div_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q <= 1'b0;
            opnd_q <= '0;
            acc_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            is_div_q <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q <= dbz_d;
            opnd_q <= opnd_d;
            acc_q <= acc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi = hi_q;
    assign lo = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO, latency and busy-window checks.
module tb_mult_div_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int tests = 0, failed = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one op; inj>0 drives a stray start with other operands at cycle N+inj
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat, input int inj);
        logic [31:0] prev_hi;
        int n, bc;
        prev_hi = hi;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        bc = 0;
        while (!done && n < 200) begin
            if (busy) bc++;
            if (n == 3 && lat > 1) check({tag, "_hold"}, hi, prev_hi);
            if (n == inj) begin
                op = 2'b11; a = 32'd7; b = 32'd9; start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_busy"}, 32'(bc), 32'(lat - 1));
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ed});
        tick();
        check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        int dn;
        repeat (2) tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;
        tick();
        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 0);
        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 0);
        run("mult_nn", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, 34, 0);
        run("multu_sh", 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34, 0);
        run("mult_min", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0);
        run("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0);
        run("divu_big", 2'b11, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 34, 0);
        run("divu_zero", 2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1, 0);
        run("div_clr", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 0);
        run("multu_ign", 2'b01, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 1'b0, 34, 5);
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        dn = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        check("abort_nodone", 32'(dn), 32'd0);
        run("post_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
